// File: rtl/chimp_pkg.sv
// Chimp-test grid geometry, shared with the click decoder so that drawn boxes and
// clickable regions coincide. Also holds the box-draw FSM state type.
package chimp_pkg;

    localparam int unsigned X_ORIGIN = 17;
    localparam int unsigned X_PITCH  = 37;
    localparam int unsigned Y_ORIGIN = 8;
    localparam int unsigned Y_PITCH  = 28;
    localparam int unsigned BOX_W    = 20;
    localparam int unsigned BOX_H    = 20;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DRAW,
        DONE
    } draw_state_e;

endpackage

// File: rtl/chimp_box_origin.sv
// Combinational grid cell index -> top-left pixel of that cell's box.
// Worst case is cell 7 on both axes: x=276 and y=204, so neither result can wrap.
module chimp_box_origin #(
    parameter int unsigned X_ORIGIN = chimp_pkg::X_ORIGIN,
    parameter int unsigned X_PITCH  = chimp_pkg::X_PITCH,
    parameter int unsigned Y_ORIGIN = chimp_pkg::Y_ORIGIN,
    parameter int unsigned Y_PITCH  = chimp_pkg::Y_PITCH
) (
    input  logic [2:0] box_x,
    input  logic [2:0] box_y,
    output logic [9:0] base_x,
    output logic [8:0] base_y
);

    always_comb begin
        base_x = 10'(X_ORIGIN) + 10'(box_x) * 10'(X_PITCH);
        base_y = 9'(Y_ORIGIN) + 9'(box_y) * 9'(Y_PITCH);
    end

endmodule

// File: rtl/chimp_box_drawer.sv
// Rasterises one grid cell's box as a stream of framebuffer pixel writes.
// Define CHIMP_BOX_OUTLINE_EN to plot only the 1-pixel perimeter instead of a filled box.
module chimp_box_drawer
    import chimp_pkg::*;
#(
    parameter int unsigned X_ORIGIN = chimp_pkg::X_ORIGIN,
    parameter int unsigned X_PITCH  = chimp_pkg::X_PITCH,
    parameter int unsigned Y_ORIGIN = chimp_pkg::Y_ORIGIN,
    parameter int unsigned Y_PITCH  = chimp_pkg::Y_PITCH,
    parameter int unsigned BOX_W    = chimp_pkg::BOX_W,
    parameter int unsigned BOX_H    = chimp_pkg::BOX_H
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic       iStart,
    input  logic [2:0] iBoxX,
    input  logic [2:0] iBoxY,
    input  logic [2:0] iColour,
    input  logic       iReady,
    output logic [9:0] oX,
    output logic [8:0] oY,
    output logic [2:0] oColour,
    output logic       oPlot,
    output logic       oBusy,
    output logic       oDone
);

    localparam int unsigned DX_W = $clog2(BOX_W);
    localparam int unsigned DY_W = $clog2(BOX_H);

    draw_state_e     state_q, state_d;
    logic [2:0]      box_x_q, box_x_d;
    logic [2:0]      box_y_q, box_y_d;
    logic [2:0]      colour_q, colour_d;
    logic [9:0]      base_x_q, base_x_d;
    logic [8:0]      base_y_q, base_y_d;
    logic [DX_W-1:0] dx_q, dx_d;
    logic [DY_W-1:0] dy_q, dy_d;

    logic [9:0]      origin_x;
    logic [8:0]      origin_y;
    logic            dx_last;
    logic            dy_last;

    chimp_box_origin #(
        .X_ORIGIN (X_ORIGIN),
        .X_PITCH  (X_PITCH),
        .Y_ORIGIN (Y_ORIGIN),
        .Y_PITCH  (Y_PITCH)
    ) u_origin (
        .box_x  (box_x_q),
        .box_y  (box_y_q),
        .base_x (origin_x),
        .base_y (origin_y)
    );

    assign dx_last = (dx_q == DX_W'(BOX_W - 1));
    assign dy_last = (dy_q == DY_W'(BOX_H - 1));

    always_comb begin
        state_d  = state_q;
        box_x_d  = box_x_q;
        box_y_d  = box_y_q;
        colour_d = colour_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;

        unique case (state_q)
            IDLE: begin
                if (iStart) begin
                    box_x_d  = iBoxX;
                    box_y_d  = iBoxY;
                    colour_d = iColour;
                    state_d  = CALC;
                end
            end
            CALC: begin
                base_x_d = origin_x;
                base_y_d = origin_y;
                dx_d     = '0;
                dy_d     = '0;
                state_d  = DRAW;
            end
            DRAW: begin
                if (iReady) begin
                    if (dx_last && dy_last) begin
                        dx_d    = '0;
                        dy_d    = '0;
                        state_d = DONE;
                    end else if (dx_last) begin
                        dx_d = '0;
                        dy_d = dy_q + 1'b1;
`ifdef CHIMP_BOX_OUTLINE_EN
                    end else if (dx_q == '0 && dy_q != '0 && !dy_last) begin
                        // Interior row: skip straight from the left edge to the right edge.
                        dx_d = DX_W'(BOX_W - 1);
`endif
                    end else begin
                        dx_d = dx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q  <= IDLE;
            box_x_q  <= '0;
            box_y_q  <= '0;
            colour_q <= '0;
            base_x_q <= '0;
            base_y_q <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
        end else begin
            state_q  <= state_d;
            box_x_q  <= box_x_d;
            box_y_q  <= box_y_d;
            colour_q <= colour_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
        end
    end

    assign oX      = base_x_q + 10'(dx_q);
    assign oY      = base_y_q + 9'(dy_q);
    assign oColour = colour_q;
    assign oPlot   = (state_q == DRAW);
    assign oBusy   = (state_q != IDLE);
    assign oDone   = (state_q == DONE);

endmodule

// File: tb/tb_chimp_box_drawer.sv
// Randomised bench for chimp_box_drawer against a pixel-list model of the box geometry.
// Honours CHIMP_BOX_OUTLINE_EN so the same bench covers both build variants.
module tb_chimp_box_drawer;

    logic       clk = 1'b0;
    logic       iReset, iStart, iReady;
    logic [2:0] iBoxX, iBoxY, iColour;
    logic [9:0] oX;
    logic [8:0] oY;
    logic [2:0] oColour;
    logic       oPlot, oBusy, oDone;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CHIMP_BOX_OUTLINE_EN
    localparam int NPLOT   = 76;
    localparam bit OUTLINE = 1'b1;
`else
    localparam int NPLOT   = 400;
    localparam bit OUTLINE = 1'b0;
`endif

    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    chimp_box_drawer dut (
        .clk     (clk),
        .iReset  (iReset),
        .iStart  (iStart),
        .iBoxX   (iBoxX),
        .iBoxY   (iBoxY),
        .iColour (iColour),
        .iReady  (iReady),
        .oX      (oX),
        .oY      (oY),
        .oColour (oColour),
        .oPlot   (oPlot),
        .oBusy   (oBusy),
        .oDone   (oDone)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Expected pixels of a cell in raster order, as packed {x, y}.
    function automatic void build_expected(input int bx, input int by);
        int x0, y0;
        x0 = 17 + bx * 37;
        y0 = 8 + by * 28;
        exp_q.delete();
        for (int dy = 0; dy < 20; dy++)
            for (int dx = 0; dx < 20; dx++)
                if (!OUTLINE || dy == 0 || dy == 19 || dx == 0 || dx == 19)
                    exp_q.push_back({10'(x0 + dx), 9'(y0 + dy)});
    endfunction

    // mode 0: iReady always high, 1: alternating, 2: random.
    task automatic run_box(input int bx, input int by, input logic [2:0] col, input int mode,
                           input bit inject, input int reset_after,
                           output logic [18:0] first_xy, output logic [18:0] last_xy);
        int          cycles, plots;
        logic [18:0] cur, held;
        bit          stalled;
        first_xy = '0;
        last_xy  = '0;
        build_expected(bx, by);
        iBoxX   = 3'(bx);
        iBoxY   = 3'(by);
        iColour = col;
        iStart  = 1'b1;
        @(posedge clk); #1;
        iStart  = 1'b0;
        cycles  = 1;
        plots   = 0;
        stalled = 1'b0;
        held    = '0;
        check_eq("calc_busy", 32'(oBusy), 1);
        check_eq("calc_plot", 32'(oPlot), 0);
        while (cycles < 3000 && !oDone) begin
            cur = {oX, oY};
            case (mode)
                0:       iReady = 1'b1;
                1:       iReady = (cycles % 2 == 0);
                default: iReady = 1'($urandom_range(0, 1));
            endcase
            iStart = 1'b0;
            if (oPlot) begin
                if (stalled) check_eq("stall_hold", 32'(cur), 32'(held));
                if (iReady) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_plot", plots + 1, NPLOT);
                    end else begin
                        check_eq("pixel", 32'(cur), 32'(exp_q.pop_front()));
                        check_eq("colour", 32'(oColour), 32'(col));
                        if (plots == 0) first_xy = cur;
                        last_xy = cur;
                        plots++;
                    end
                    stalled = 1'b0;
                end else begin
                    held    = cur;
                    stalled = 1'b1;
                end
                if (inject && plots == 50 && !stalled) begin
                    iStart  = 1'b1;
                    iBoxX   = 3'd5;
                    iBoxY   = 3'd5;
                    iColour = ~col;
                end
                if (reset_after > 0 && plots == reset_after) begin
                    iReset = 1'b1;
                    @(posedge clk); #1;
                    iReset = 1'b0;
                    check_eq("rst_plot", 32'(oPlot), 0);
                    check_eq("rst_busy", 32'(oBusy), 0);
                    check_eq("rst_done", 32'(oDone), 0);
                    for (int i = 0; i < 5; i++) begin
                        @(posedge clk); #1;
                        check_eq("post_rst_quiet", 32'({oPlot, oBusy, oDone}), 0);
                    end
                    return;
                end
            end
            @(posedge clk); #1;
            cycles++;
        end
        iStart = 1'b0;
        check_eq("done_seen", 32'(oDone), 1);
        check_eq("done_busy", 32'(oBusy), 1);
        check_eq("done_plot", 32'(oPlot), 0);
        check_eq("plot_count", plots, NPLOT);
        check_eq("missing_pixels", exp_q.size(), 0);
        if (mode == 0) check_eq("latency", cycles, 2 + NPLOT);
        if (inject) begin
            iStart  = 1'b1;
            iBoxX   = 3'd5;
            iBoxY   = 3'd5;
        end
        @(posedge clk); #1;
        iStart = 1'b0;
        check_eq("idle_after_done", 32'({oBusy, oDone, oPlot}), 0);
        @(posedge clk); #1;
        check_eq("idle_stays", 32'({oBusy, oDone, oPlot}), 0);
    endtask

    initial begin
        logic [18:0] f, l;
        iReset  = 1'b1;
        iStart  = 1'b0;
        iReady  = 1'b0;
        iBoxX   = '0;
        iBoxY   = '0;
        iColour = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_x", 32'(oX), 0);
        check_eq("reset_y", 32'(oY), 0);
        check_eq("reset_colour", 32'(oColour), 0);
        check_eq("reset_plot", 32'(oPlot), 0);
        check_eq("reset_busy", 32'(oBusy), 0);
        check_eq("reset_done", 32'(oDone), 0);
        iReset = 1'b0;
        @(posedge clk); #1;

        run_box(0, 0, 3'b011, 0, 1'b0, 0, f, l);
        check_eq("cell00_first", 32'(f), 32'({10'd17, 9'd8}));
        check_eq("cell00_last", 32'(l), 32'({10'd36, 9'd27}));

        run_box(7, 7, 3'b101, 0, 1'b0, 0, f, l);
        check_eq("cell77_first", 32'(f), 32'({10'd276, 9'd204}));
        check_eq("cell77_last", 32'(l), 32'({10'd295, 9'd223}));

        run_box(3, 2, 3'b110, 1, 1'b0, 0, f, l);
        check_eq("cell32_first", 32'(f), 32'({10'd128, 9'd64}));

        run_box(2, 4, 3'b010, 0, 1'b1, 0, f, l);

        run_box(4, 6, 3'b111, 0, 1'b0, 100, f, l);
        run_box(6, 1, 3'b001, 0, 1'b0, 0, f, l);
        check_eq("after_rst_first", 32'(f), 32'({10'd239, 9'd36}));

        run_box(1, 1, 3'b100, 0, 1'b0, 0, f, l);
        check_eq("cell11_first", 32'(f), 32'({10'd54, 9'd36}));
        check_eq("cell11_last", 32'(l), 32'({10'd73, 9'd55}));

        for (int k = 0; k < 6; k++)
            run_box(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 2, 1'b0, 0, f, l);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
